// File: rtl/instruction_fetch_stage_if.sv
// IF stage bus: hazard/redirect controls in, instruction memory port and IF/ID register out.
interface instruction_fetch_stage_if;
  logic        Stall;
  logic        Flush;
  logic        Branch_Taken;
  logic [63:0] Branch_Target;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] IF_ID_PC;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
  logic        Halted;
  logic        Fetch_Fault;
  logic [31:0] Fetch_Count;

  // Pipeline control / memory side that drives the fetch stage
  modport master (
    output Stall, Flush, Branch_Taken, Branch_Target, Instruction,
    input  Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
           Halted, Fetch_Fault, Fetch_Count
  );

  // Fetch stage itself
  modport slave (
    input  Stall, Flush, Branch_Taken, Branch_Target, Instruction,
    output Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
           Halted, Fetch_Fault, Fetch_Count
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches from combinational instruction
// memory and loads the IF/ID register under stall/flush/redirect control.
// Freezes on the halt idiom or on an illegal fetch until reset.
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_BYTES = 208,
  parameter logic [31:0] HALT_INSN = 32'h00000063
) (
  input logic                         clk,
  input logic                         reset,
  instruction_fetch_stage_if.slave    bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSN = 32'h00000013;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ifid_pc;
  logic [ILEN-1:0] r_ifid_insn;
  logic            r_ifid_valid;
  logic            r_halted;
  logic            r_fault;
  logic [31:0]     r_count;

  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_ifid_pc_nxt;
  logic [ILEN-1:0] w_ifid_insn_nxt;
  logic            w_ifid_valid_nxt;
  logic            w_halted_nxt;
  logic            w_fault_nxt;
  logic [31:0]     w_count_nxt;
  logic            w_frozen;
  logic            w_in_range;
  logic [XLEN-1:0] w_pc_plus4;

  // Range check in 65 bits so a PC near the top of the address space cannot wrap into range
  assign w_in_range = (({1'b0, r_pc} + 65'd3) < 65'(MEM_BYTES));
  assign w_pc_plus4 = r_pc + 64'd4;
  assign w_frozen   = r_halted | r_fault;

  // Next-state selection following the per-edge priority order
  always_comb begin
    w_pc_nxt         = r_pc;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_insn_nxt  = r_ifid_insn;
    w_ifid_valid_nxt = r_ifid_valid;
    w_halted_nxt     = r_halted;
    w_fault_nxt      = r_fault;
    w_count_nxt      = r_count;
    if (w_frozen) begin
      // hold everything
    end else if (bus.Branch_Taken && (bus.Branch_Target[1:0] != 2'b00)) begin
      w_fault_nxt      = 1'b1;
      w_ifid_pc_nxt    = r_pc;
      w_ifid_insn_nxt  = NOP_INSN;
      w_ifid_valid_nxt = 1'b0;
    end else if (bus.Branch_Taken) begin
      w_pc_nxt         = bus.Branch_Target;
      w_ifid_pc_nxt    = r_pc;
      w_ifid_insn_nxt  = NOP_INSN;
      w_ifid_valid_nxt = 1'b0;
    end else if (bus.Flush && !bus.Stall) begin
      w_pc_nxt         = w_pc_plus4;
      w_ifid_pc_nxt    = r_pc;
      w_ifid_insn_nxt  = NOP_INSN;
      w_ifid_valid_nxt = 1'b0;
    end else if (bus.Stall) begin
      // stall wins over flush so the instruction held in ID is not lost
    end else if (w_in_range) begin
      w_pc_nxt         = w_pc_plus4;
      w_ifid_pc_nxt    = r_pc;
      w_ifid_insn_nxt  = bus.Instruction;
      w_ifid_valid_nxt = 1'b1;
      w_count_nxt      = r_count + 32'd1;
      w_halted_nxt     = (bus.Instruction == HALT_INSN);
    end else begin
      w_fault_nxt      = 1'b1;
      w_ifid_pc_nxt    = r_pc;
      w_ifid_insn_nxt  = NOP_INSN;
      w_ifid_valid_nxt = 1'b0;
    end
  end

  // PC, IF/ID and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_insn  <= NOP_INSN;
      r_ifid_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_count      <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_insn  <= w_ifid_insn_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_halted     <= w_halted_nxt;
      r_fault      <= w_fault_nxt;
      r_count      <= w_count_nxt;
    end
  end

  assign bus.Inst_Address      = r_pc;
  assign bus.IF_ID_PC          = r_ifid_pc;
  assign bus.IF_ID_Instruction = r_ifid_insn;
  assign bus.IF_ID_Valid       = r_ifid_valid;
  assign bus.Halted            = r_halted;
  assign bus.Fetch_Fault       = r_fault;
  assign bus.Fetch_Count       = r_count;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized
// control traffic, checked against a behavioural model of the fetch rules.
module tb_instruction_fetch_stage;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [31:0] mem [0:63];

  // reference model state
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_ins, m_cnt;
  logic        m_v, m_halt, m_fault;

  instruction_fetch_stage_if ifc ();

  instruction_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // combinational memory: 208 bytes, zero outside
  assign ifc.Instruction = (ifc.Inst_Address <= 64'd204) ? mem[ifc.Inst_Address[7:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  ifc.Inst_Address, m_pc);
    chk({tag, ".ifpc"},  ifc.IF_ID_PC, m_ipc);
    chk({tag, ".ifins"}, 64'(ifc.IF_ID_Instruction), 64'(m_ins));
    chk({tag, ".ifv"},   64'(ifc.IF_ID_Valid), 64'(m_v));
    chk({tag, ".halt"},  64'(ifc.Halted), 64'(m_halt));
    chk({tag, ".fault"}, 64'(ifc.Fetch_Fault), 64'(m_fault));
    chk({tag, ".cnt"},   64'(ifc.Fetch_Count), 64'(m_cnt));
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_ipc = 64'h0; m_ins = 32'h13; m_v = 1'b0;
    m_halt = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_bubble();
    m_ipc = m_pc; m_ins = 32'h13; m_v = 1'b0;
  endtask

  // One clock edge of the fetch rules, applied in priority order
  task automatic model_step(input logic st, input logic fl, input logic br, input logic [63:0] tgt);
    logic [31:0] word;
    word = (m_pc <= 64'd204) ? mem[m_pc[7:2]] : 32'h0;
    if (m_halt || m_fault) return;
    if (br) begin
      if (tgt % 4 != 0) begin m_fault = 1'b1; model_bubble(); end
      else begin model_bubble(); m_pc = tgt; end
    end else if (fl && !st) begin
      model_bubble(); m_pc = m_pc + 4;
    end else if (st) begin
      // hold
    end else if (m_pc <= 64'd204) begin
      m_ipc = m_pc; m_ins = word; m_v = 1'b1; m_cnt = m_cnt + 1;
      if (word == 32'h00000063) m_halt = 1'b1;
      m_pc = m_pc + 4;
    end else begin
      m_fault = 1'b1; model_bubble();
    end
  endtask

  // Called right after a falling edge; returns right after the next falling edge
  task automatic step(input string tag, input logic st, input logic fl, input logic br, input logic [63:0] tgt);
    ifc.Stall = st; ifc.Flush = fl; ifc.Branch_Taken = br; ifc.Branch_Target = tgt;
    model_step(st, fl, br, tgt);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Assert reset between edges, check the async effect, release on the next falling edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    ifc.Stall = 1'b0; ifc.Flush = 1'b0; ifc.Branch_Taken = 1'b0; ifc.Branch_Target = 64'h0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [63:0] tgt;
    int r;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    ifc.Stall = 1'b0; ifc.Flush = 1'b0; ifc.Branch_Taken = 1'b0; ifc.Branch_Target = 64'h0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == 32'h00000063) w = 32'h00000013;
      mem[i] = w;
    end
    mem[0] = 32'h00000513;
    mem[1] = 32'h00100293;
    @(negedge clk);
    do_reset("rst0");

    // sequential fetch
    step("seq0", 0, 0, 0, 64'h0);
    chk("seq0.ins", 64'(ifc.IF_ID_Instruction), 64'h00000513);
    step("seq1", 0, 0, 0, 64'h0);
    chk("seq1.ins", 64'(ifc.IF_ID_Instruction), 64'h00100293);
    chk("seq1.pc", ifc.IF_ID_PC, 64'd4);
    chk("seq1.cnt", 64'(ifc.Fetch_Count), 64'd2);
    chk("seq1.addr", ifc.Inst_Address, 64'd8);

    // branch redirect at PC 84
    step("br0", 0, 0, 1, 64'd84);
    step("br1", 0, 0, 1, 64'd88);
    chk("br1.v", 64'(ifc.IF_ID_Valid), 64'd0);
    chk("br1.addr", ifc.Inst_Address, 64'd88);
    step("br2", 0, 0, 0, 64'h0);
    chk("br2.pc", ifc.IF_ID_PC, 64'd88);
    chk("br2.v", 64'(ifc.IF_ID_Valid), 64'd1);

    // stall beats flush, then flush alone, then branch beats stall
    step("sf0", 0, 0, 1, 64'd12);
    step("sf1", 0, 0, 0, 64'h0);
    for (int k = 0; k < 3; k++) step("sfst", 1, 1, 0, 64'h0);
    chk("sfst.addr", ifc.Inst_Address, 64'd16);
    chk("sfst.pc", ifc.IF_ID_PC, 64'd12);
    step("sffl", 0, 1, 0, 64'h0);
    chk("sffl.addr", ifc.Inst_Address, 64'd20);
    chk("sffl.v", 64'(ifc.IF_ID_Valid), 64'd0);
    step("sfbr", 1, 0, 1, 64'd40);
    chk("sfbr.addr", ifc.Inst_Address, 64'd40);

    // misaligned redirect
    step("mis0", 0, 0, 1, 64'h5A);
    chk("mis0.f", 64'(ifc.Fetch_Fault), 64'd1);
    chk("mis0.addr", ifc.Inst_Address, 64'd40);
    step("mis1", 0, 0, 0, 64'h0);
    step("mis2", 0, 0, 1, 64'd8);
    do_reset("rst1");

    // randomized control traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       tgt = 64'($urandom_range(0, 51)) * 4 + 64'($urandom_range(1, 3));
      else if (r < 10) tgt = 64'd208 + 64'($urandom_range(0, 8)) * 4;
      else             tgt = 64'($urandom_range(0, 51)) * 4;
      step("rnd", ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 8), tgt);
      if (m_halt || m_fault) do_reset("rndrst");
    end

    // out of range without halt
    step("oor0", 0, 0, 1, 64'd200);
    step("oor1", 0, 0, 0, 64'h0);
    step("oor2", 0, 0, 0, 64'h0);
    step("oor3", 0, 0, 0, 64'h0);
    chk("oor3.f", 64'(ifc.Fetch_Fault), 64'd1);
    chk("oor3.v", 64'(ifc.IF_ID_Valid), 64'd0);
    do_reset("rst2");

    // halt idiom at the last word
    mem[51] = 32'h00000063;
    step("hlt0", 0, 0, 1, 64'd204);
    step("hlt1", 0, 0, 0, 64'h0);
    chk("hlt1.h", 64'(ifc.Halted), 64'd1);
    chk("hlt1.pc", ifc.IF_ID_PC, 64'd204);
    chk("hlt1.addr", ifc.Inst_Address, 64'd208);
    step("hlt2", 0, 0, 1, 64'd16);
    chk("hlt2.addr", ifc.Inst_Address, 64'd208);
    do_reset("rst3");
    chk("rst3.h", 64'(ifc.Halted), 64'd0);

    // async reset mid-run at PC 52
    step("ar0", 0, 0, 1, 64'd48);
    step("ar1", 0, 0, 0, 64'h0);
    chk("ar1.addr", ifc.Inst_Address, 64'd52);
    do_reset("ar2");
    step("ar3", 0, 0, 0, 64'h0);
    chk("ar3.pc", ifc.IF_ID_PC, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
